// File: rtl/dmem_arbiter_pkg.sv
// darb_pkg: shared encodings for the dmem arbiter.
//   darb_state_e : FSM states IDLE / ACCESS / RESP
//   PORT0/PORT1  : requester index carried in the grant select
//   DMEM_WR/RD   : REDMEM pin encoding (1 = write cycle)
package darb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } darb_state_e;

  localparam logic PORT0   = 1'b0;
  localparam logic PORT1   = 1'b1;
  localparam logic DMEM_WR = 1'b1;
  localparam logic DMEM_RD = 1'b0;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/grant/response signals of both requesters plus
// the dmem pins.
//   slave  : arbiter view (takes requests and dmem_data, drives grants/dmem pins)
//   master : requesters + dmem view (drives requests and dmem_data)
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] read_val;
  logic          REDMEM;
  logic [DW-1:0] dmem_data;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, dmem_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           dmem_addr, read_val, REDMEM, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, dmem_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           dmem_addr, read_val, REDMEM, busy
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// darb_rr_pick: combinational 2-port grant picker.
//   i_req0/i_req1 : pending requests
//   i_last_gnt    : port granted last time
//   o_any         : at least one request pending
//   o_sel         : winning port (meaningful only when o_any)
// Build option DARB_FIXED_PRIO_EN: port 0 wins every tie, history ignored.
module darb_rr_pick
  import darb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_any,
  output logic o_sel
);
  assign o_any = i_req0 | i_req1;

`ifdef DARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = i_last_gnt;
  assign o_sel    = i_req0 ? PORT0 : PORT1;
`else
  always_comb begin
    o_sel = i_req0 ? PORT0 : PORT1;
    // On a tie hand the grant to whichever port did not win last time.
    if (i_req0 && i_req1)
      o_sel = (i_last_gnt == PORT0) ? PORT1 : PORT0;
  end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between port 0 (CPU) and
// port 1 (DMA/debug). Non-pipelined: write = 2 cycles, read = 3 cycles.
//   clk, reset_darb : clock, async active-high reset
//   bus (slave)     : req/we/addr/wdata in, gnt/rvalid/rdata out per port;
//                     dmem_addr/read_val/REDMEM to dmem, dmem_data from dmem;
//                     busy high outside IDLE
// Build option DARB_FIXED_PRIO_EN: fixed priority (port 0) instead of
// round-robin; no grant history register is kept.
module dmem_arbiter
  import darb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_darb,
  dmem_arbiter_if.slave bus
);
  darb_state_e   r_state;
  logic          r_sel, r_we;
  logic          r_gnt0, r_gnt1, r_rvalid0, r_rvalid1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic [AW-1:0] r_dmem_addr;
  logic [DW-1:0] r_read_val;
  logic          r_redmem, r_busy;

  logic          w_any, w_sel, w_last, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

`ifdef DARB_FIXED_PRIO_EN
  assign w_last = PORT1;
`else
  logic r_last_gnt;
  assign w_last = r_last_gnt;
`endif

  darb_rr_pick u_pick (
    .i_req0    (bus.req0),
    .i_req1    (bus.req1),
    .i_last_gnt(w_last),
    .o_any     (w_any),
    .o_sel     (w_sel)
  );

  assign w_we    = (w_sel == PORT1) ? bus.we1    : bus.we0;
  assign w_addr  = (w_sel == PORT1) ? bus.addr1  : bus.addr0;
  assign w_wdata = (w_sel == PORT1) ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or posedge reset_darb) begin
    if (reset_darb) begin
      r_state     <= IDLE;
      r_sel       <= PORT0;
      r_we        <= DMEM_RD;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_dmem_addr <= '0;
      r_read_val  <= '0;
      r_redmem    <= DMEM_RD;
      r_busy      <= 1'b0;
`ifndef DARB_FIXED_PRIO_EN
      r_last_gnt  <= PORT1;  // port 0 wins the first tie
`endif
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            // Command is captured here; later changes on the port are ignored.
            r_sel       <= w_sel;
            r_we        <= w_we;
            r_dmem_addr <= w_addr;
            r_read_val  <= w_wdata;
            r_redmem    <= w_we ? DMEM_WR : DMEM_RD;
            r_gnt0      <= (w_sel == PORT0);
            r_gnt1      <= (w_sel == PORT1);
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
`ifndef DARB_FIXED_PRIO_EN
            r_last_gnt  <= w_sel;
`endif
          end
        end
        ACCESS: begin
          r_redmem <= DMEM_RD;
          if (r_we) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        RESP: begin
          // dmem has registered the read by now; hand it to the issuer.
          if (r_sel == PORT0) begin
            r_rdata0  <= bus.dmem_data;
            r_rvalid0 <= 1'b1;
          end else begin
            r_rdata1  <= bus.dmem_data;
            r_rvalid1 <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.dmem_addr = r_dmem_addr;
  assign bus.read_val  = r_read_val;
  assign bus.REDMEM    = r_redmem;
  assign bus.busy      = r_busy;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory (dmem) between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).
- Accepts req/gnt transactions and drives the dmem address, write-data and write-strobe pins.
- Returns read data to the requester that issued the read.
- Default arbitration is round-robin. A macro switches it to fixed priority.

Parameters:
- AW, 8, address width (matches dmem_addr)
- DW, 8, data width (matches read_val/data)

Ports:
- clk  in  1  system clock, rising edge
- reset_darb  in  1  reset, asynchronous, active-high
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0: 1 = write, 0 = read
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- gnt0  out  1  one-cycle pulse: port 0 command accepted and driven to dmem
- rvalid0  out  1  one-cycle pulse: rdata0 valid
- rdata0  out  DW  port 0 read data; holds until the next port 0 read completes
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- dmem_addr  out  AW  to dmem dmem_addr
- read_val  out  DW  to dmem read_val (write data)
- REDMEM  out  1  to dmem REDMEM; 1 = write cycle, 0 = read/no-op
- dmem_data  in  DW  from dmem data (registered read output)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Outputs clear to 0: gnt*, rvalid*, rdata*, dmem_addr, read_val, REDMEM, busy.
  - last_gnt resets to 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req0/req1 are sampled only in IDLE. If any is set, the arbiter latches the winner's we/addr/wdata into the command registers, records the winner in sel, and goes to ACCESS.
  - Otherwise it stays in IDLE.
- ACCESS (exactly 1 cycle):
  - dmem_addr = latched addr; read_val = latched wdata; REDMEM = latched we.
  - gnt[sel] is high for this cycle only.
  - Write: next state is IDLE, and REDMEM returns to 0.
  - Read: next state is RESP.
- RESP (exactly 1 cycle):
  - REDMEM = 0; dmem_addr is held.
  - At the end of the cycle, dmem_data is registered into rdata[sel] and rvalid[sel] pulses in the following cycle.
  - Next state is IDLE.
- Latency from req sampled in IDLE at cycle T:
  - gnt at T+1.
  - Write completes in dmem at the end of T+1.
  - rvalid/rdata at T+3.
- Throughput: a write occupies 2 cycles and a read 3 cycles. No pipelining.
- Round-robin arbitration:
  - One request only: grant it.
  - Both requesting: grant the port != last_gnt.
  - last_gnt updates on every grant.
- Handshake rules:
  - A requester may drop req before gnt (withdrawal).
  - Once its command is latched, the transaction completes even if req drops. Changes to addr/wdata after latching are ignored.
  - A requester must deassert req in the cycle after gnt, or it is treated as a new request.
- rvalid0 and rvalid1 are never high in the same cycle. gnt0 and gnt1 are never high in the same cycle.
- Wrap-around: addresses are passed through unmodified; 8'hFF is a legal address.
- Reset mid-transaction:
  - REDMEM drops to 0 immediately, so no spurious write occurs.
  - Any in-flight read is discarded; no rvalid is produced.
- The arbiter does not drive dmem's own reset.

Optional Feature:
- Macro: DARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports request. last_gnt is not implemented. Port 1 may starve; this is accepted.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Shared package darb_pkg holds:
  - FSM state encodings: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port index constants: PORT0 = 1'b0, PORT1 = 1'b1.
  - REDMEM encoding constants: DMEM_WR = 1'b1, DMEM_RD = 1'b0.
- One sub-module, darb_rr_pick: a 2-input grant picker.
  - Inputs: req0, req1, last_gnt.
  - Outputs: any, sel.
  - Purely combinational. The fixed-priority variant is selected inside it by DARB_FIXED_PRIO_EN.

Test Plan:
- Reset then idle -> all outputs 0, busy = 0. Assert reset_darb mid-ACCESS of a write -> REDMEM falls to 0 asynchronously, state is IDLE.
- Port 0 write addr 8'h00, data 8'h55, then port 0 read 8'h00 -> gnt0 at T+1 with REDMEM = 1; read returns rdata0 = 8'h55 with rvalid0 three cycles after its req was sampled.
- req0 and req1 both reads from reset, to 8'h10 and 8'h20 -> grant order port 0 then port 1. With both held, grants alternate 0, 1, 0, 1.
- Port 1 write 8'hFF = 8'hA5, port 0 read 8'hFF -> rdata0 = 8'hA5; rvalid1 never asserts.
- Port 0 read latched, then addr0 changed and req0 dropped during ACCESS -> the original address is read and rvalid0 still pulses.
- With DARB_FIXED_PRIO_EN defined and both ports continuously requesting -> only gnt0 ever pulses.
